uart_rx_edge_sequencer: RTL
===========================

// Module: uart_rx_edge_sequencer
// PURPOSE
//  UART receive-side controller sequencing the falling-edge detector on the RX line.
//  Synchronises rx_in; a falling edge arms start-bit qualification.
//  Counts oversample baud ticks to sample each bit at mid-bit and assembles the frame.
//  Sits between the baud generator and the APB register block; delivers one byte per valid pulse.
// PARAMETERS
//  OVERSAMPLE   16  baud_tick pulses per bit; even, >=4
//  DATA_BITS    8   data bits per frame, 5..8, LSB first
//  SYNC_STAGES  2   flops in rx_in synchroniser, >=2
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  baud_tick  in   1          1-cycle strobe at OVERSAMPLE x baud rate
//  rx_in      in   1          asynchronous serial input, idle high
//  rx_en      in   1          receiver enable
//  rx_data    out  DATA_BITS  last received byte, held until next valid
//  rx_valid   out  1          1-cycle pulse: rx_data/frame_err updated
//  frame_err  out  1          stop bit sampled 0 on last frame
//  busy       out  1          state != IDLE
//  par_odd    in   1          [UART_RX_PARITY_EN only] 1=odd, 0=even parity
//  parity_err out  1          [UART_RX_PARITY_EN only] parity mismatch on last frame
// BEHAVIOUR
//  Reset: sync chain=1, state IDLE, counters 0, rx_data=0, rx_valid=0, frame_err=0, busy=0.
//  Edge detect on synchronised rx_s (internal sub-module); only the falling pulse is used.
//  FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; tick_cnt width $clog2(OVERSAMPLE), bit_cnt $clog2(DATA_BITS+1).
//  IDLE: rx_en=1 and fall pulse -> START, tick_cnt=0. Fall pulse ignored in all other states.
//  START: on tick_cnt==OVERSAMPLE/2-1 with baud_tick, sample rx_s: 1 -> IDLE (false start, no
//    rx_valid); 0 -> DATA, tick_cnt=0, bit_cnt=0.
//  DATA: tick_cnt wraps at OVERSAMPLE-1; at each wrap shift rx_s into MSB of shift reg;
//    after DATA_BITS samples -> PARITY (macro) else STOP. rx_data is right-aligned.
//  STOP: at wrap sample rx_s; next cycle rx_valid=1, rx_data=shift reg, frame_err=~sample; -> IDLE.
//  Latency: rx_valid is registered, 1 clk after the baud_tick taking the stop mid-sample.
//  Byte is delivered even when frame_err=1. rx_data/frame_err hold between valids.
//  Back-to-back: fall pulse in the clk after STOP->IDLE is accepted (no dead tick).
//  rx_en=0 in any state: next state IDLE, frame discarded, no rx_valid, outputs held.
//  baud_tick low: counters and state frozen; rx_valid never asserts without a preceding tick.
//  Async reset mid-frame: immediate IDLE, outputs to reset values, partial frame lost.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state after DATA samples one bit at wrap;
//    parity_err = (^data ^ bit) != par_odd, updated with rx_valid; reset 0. Ports exist.
//  Undefined: no PARITY state, no par_odd/parity_err ports; DATA -> STOP directly.
// STRUCTURE
//  Shared package uart_pkg.vh: FSM state encodings (S_IDLE..S_STOP), default OVERSAMPLE/DATA_BITS.
//  One sub-module: uart_rx_fall_detect (clk, rst_n, level -> fall pulse, registered prior level,
//    prior level resets to 1 so the line idling high after reset gives no pulse).
//  Synchroniser, counters, shift reg and FSM live in this module.
// TESTING (OVERSAMPLE=16, DATA_BITS=8, tick every clk unless stated)
//  1 Frame 0xA5, stop=1 -> one rx_valid, rx_data=8'hA5, frame_err=0, busy low after.
//  2 rx_in low for 4 ticks then high -> false start: no rx_valid, back in IDLE, busy=0.
//  3 Frame 0x3C with stop=0 -> rx_valid, rx_data=8'h3C, frame_err=1; next good frame clears it.
//  4 Frames 0x00 then 0xFF back-to-back, no idle gap -> two rx_valid, 0x00 then 0xFF.
//  5 rx_en dropped at bit 4 of 0x55 -> no rx_valid, IDLE next clk; re-enable, 0x12 received.
//  6 rst_n low at bit 3 of 0x81 -> all outputs 0 immediately; next frame 0x7E received clean.
//  (PARITY_EN) 0xA5 even parity, parity bit 0 -> parity_err=0; bit 1 -> parity_err=1.

Source files
------------

// File: rtl/uart_rx_edge_sequencer_pkg.sv
// Shared definitions for the UART receive sequencer.
//   - Default frame geometry (OVERSAMPLE, DATA_BITS).
//   - FSM state encodings S_IDLE..S_STOP, kept as fixed-width constants so the
//     encoding stays identical to the legacy register map.
package uart_rx_edge_sequencer_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_edge_sequencer_fall_detect.sv
// Falling-edge detector for the synchronised RX level.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   level  in  synchronised line level
//   fall   out single-cycle pulse while level is 0 and the prior level was 1
// The prior level resets to 1 so a line idling high after reset never pulses.
module uart_rx_fall_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level;
    end
  end

  assign fall = prev_q & ~level;

endmodule

// File: rtl/uart_rx_edge_sequencer.sv
// UART receive sequencer: synchronises rx_in, arms start-bit qualification on
// a falling edge, counts oversample baud ticks to sample each bit at mid-bit
// and delivers one assembled frame per rx_valid pulse.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, par_odd and
// parity_err ports).
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   baud_tick  in   1-cycle strobe at OVERSAMPLE x baud rate
//   rx_in      in   asynchronous serial input, idle high
//   rx_en      in   receiver enable; low aborts any frame in progress
//   par_odd    in   [UART_RX_PARITY_EN] 1=odd, 0=even parity
//   parity_err out  [UART_RX_PARITY_EN] parity mismatch on last frame
//   rx_data    out  last received data, right-aligned, held between valids
//   rx_valid   out  1-cycle pulse: rx_data/frame_err updated
//   frame_err  out  stop bit sampled 0 on last frame
//   busy       out  receiver not idle
module uart_rx_edge_sequencer
  import uart_rx_edge_sequencer_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  input  logic                 rx_en,
`ifdef UART_RX_PARITY_EN
  input  logic                 par_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_WRAP = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  // Input synchroniser, idles high like the line.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_fall_detect u_fall (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rx_s),
    .fall  (fall)
  );

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick_wrap;
`ifdef UART_RX_PARITY_EN
  logic                 pbit_q, pbit_d;
  logic                 perr_q, perr_d;
`endif

  assign tick_wrap = (tick_q == TICK_WRAP);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = perr_q;
`endif
    if (!rx_en) begin
      // Abort: frame discarded, delivered outputs untouched.
      state_d = S_IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Edge is taken regardless of baud_tick so a short pulse is never missed.
          if (fall) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (tick_q == TICK_MID) begin
              if (rx_s) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_DATA;
                tick_d  = '0;
                bit_d   = '0;
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (tick_wrap) begin
              tick_d  = '0;
              // LSB arrives first; shifting in at the MSB leaves it right-aligned.
              shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
              bit_d   = bit_q + 1'b1;
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = S_STOP;
`endif
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            if (tick_wrap) begin
              tick_d  = '0;
              pbit_d  = rx_s;
              state_d = S_STOP;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            if (tick_wrap) begin
              state_d = S_IDLE;
              tick_d  = '0;
              valid_d = 1'b1;
              data_d  = shreg_q;
              ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
              perr_d  = ((^shreg_q) ^ pbit_q) != par_odd;
`endif
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule
